// File: rtl/connect4_turn_scheduler_if.sv
// Command bus between the button/game-state side and the turn scheduler.
// The master drives the debounced button pulses and the FSM status.
// The slave (the scheduler) drives the command pulses and the turn timer.
interface connect4_turn_scheduler_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_accept;
  logic       btn_reset;
  logic [2:0] game_state;
  logic       win_flag;
  logic       move_left;
  logic       move_right;
  logic       move_made;
  logic       game_reset;
  logic [3:0] seconds;
  logic       auto_move;

  modport master (
    output btn_left, btn_right, btn_accept, btn_reset, game_state, win_flag,
    input  move_left, move_right, move_made, game_reset, seconds, auto_move
  );

  modport slave (
    input  btn_left, btn_right, btn_accept, btn_reset, game_state, win_flag,
    output move_left, move_right, move_made, game_reset, seconds, auto_move
  );
endinterface

// File: rtl/connect4_turn_scheduler.sv
// Single arbiter in front of connect4_fsm: merges button pulses, the per-turn
// timeout and the post-win auto-restart into at most one command per cycle.
// All commands are registered and appear one cycle after their cause.
// TICK_CYCLES must be at least 2; TURN_SECONDS must fit in 4 bits.
module connect4_turn_scheduler #(
  parameter int          TICK_CYCLES     = 25_000_000,
  parameter int          TURN_SECONDS    = 10,
  parameter int          WIN_HOLD_CYCLES = 12_500_000,
  parameter logic [2:0]  PLAY_STATE      = 3'b001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  connect4_turn_scheduler_if.slave     bus
);

  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam int HOLD_W = $clog2(WIN_HOLD_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD_CYCLES - 1);
  localparam logic [3:0]        SEC_MAX   = 4'(TURN_SECONDS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    WIN_HOLD = 2'd2
  } state_t;

  state_t              state_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [3:0]          seconds_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [1:0]          lock_cnt_reg;
  logic                win_prev_reg;
  logic                move_left_reg;
  logic                move_right_reg;
  logic                move_made_reg;
  logic                game_reset_reg;
  logic                auto_move_reg;

  logic win_rise;
  logic locked;
  logic timeout;

  // Win edge, post-command settle window and turn expiry.
  assign win_rise = bus.win_flag & ~win_prev_reg;
  assign locked   = (lock_cnt_reg != 2'd0);
  assign timeout  = (state_reg == PLAY) && (seconds_reg == SEC_MAX) && !locked;

  // Scheduler FSM: timer, win hold and prioritised command issue.
  // Later non-blocking assignments deliberately override earlier ones so the
  // button/timeout section can clear the timer the case statement advanced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      seconds_reg    <= '0;
      hold_cnt_reg   <= '0;
      lock_cnt_reg   <= '0;
      win_prev_reg   <= 1'b0;
      move_left_reg  <= 1'b0;
      move_right_reg <= 1'b0;
      move_made_reg  <= 1'b0;
      game_reset_reg <= 1'b0;
      auto_move_reg  <= 1'b0;
    end else begin
      move_left_reg  <= 1'b0;
      move_right_reg <= 1'b0;
      move_made_reg  <= 1'b0;
      game_reset_reg <= 1'b0;
      auto_move_reg  <= 1'b0;
      win_prev_reg   <= bus.win_flag;
      if (locked) lock_cnt_reg <= lock_cnt_reg - 2'd1;

      if (bus.btn_reset && !locked) begin
        // Manual reset beats everything, including a pending win hold.
        game_reset_reg <= 1'b1;
        state_reg      <= IDLE;
        tick_cnt_reg   <= '0;
        seconds_reg    <= '0;
        hold_cnt_reg   <= '0;
        lock_cnt_reg   <= 2'd2;
      end else if (win_rise) begin
        // A fresh win drops any same-cycle button or timeout.
        state_reg    <= WIN_HOLD;
        hold_cnt_reg <= '0;
        tick_cnt_reg <= '0;
        seconds_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            tick_cnt_reg <= '0;
            seconds_reg  <= '0;
            if (bus.game_state == PLAY_STATE) state_reg <= PLAY;
          end
          PLAY: begin
            if (bus.game_state != PLAY_STATE) begin
              state_reg    <= IDLE;
              tick_cnt_reg <= '0;
              seconds_reg  <= '0;
            end else if (seconds_reg < SEC_MAX) begin
              if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg <= '0;
                seconds_reg  <= seconds_reg + 4'd1;
              end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
              end
            end
          end
          WIN_HOLD: begin
            if (hold_cnt_reg == HOLD_LAST) begin
              game_reset_reg <= 1'b1;
              state_reg      <= IDLE;
              hold_cnt_reg   <= '0;
              lock_cnt_reg   <= 2'd2;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase

        // Player buttons and the timeout; silent during a win or settle window.
        if (state_reg != WIN_HOLD && !locked) begin
          if (bus.btn_accept) begin
            move_made_reg <= 1'b1;
            tick_cnt_reg  <= '0;
            seconds_reg   <= '0;
            lock_cnt_reg  <= 2'd2;
          end else if (timeout) begin
            move_made_reg <= 1'b1;
            auto_move_reg <= 1'b1;
            tick_cnt_reg  <= '0;
            seconds_reg   <= '0;
            state_reg     <= IDLE;
            lock_cnt_reg  <= 2'd2;
          end else if (bus.btn_left ^ bus.btn_right) begin
            move_left_reg  <= bus.btn_left;
            move_right_reg <= bus.btn_right;
          end
        end
      end
    end
  end

  assign bus.move_left  = move_left_reg;
  assign bus.move_right = move_right_reg;
  assign bus.move_made  = move_made_reg;
  assign bus.game_reset = game_reset_reg;
  assign bus.auto_move  = auto_move_reg;
  assign bus.seconds    = seconds_reg;

endmodule

// File: tb/tb_connect4_turn_scheduler.sv
// Directed bench for connect4_turn_scheduler with a short timer
// (4 ticks/second, 3-second turns, 8-cycle win hold).
// Outputs are packed as {move_left, move_right, move_made, game_reset, auto_move}.
module tb_connect4_turn_scheduler;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  connect4_turn_scheduler_if bus ();

  connect4_turn_scheduler #(
    .TICK_CYCLES     (4),
    .TURN_SECONDS    (3),
    .WIN_HOLD_CYCLES (8),
    .PLAY_STATE      (3'b001)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] outs();
    return {3'b000, bus.move_left, bus.move_right, bus.move_made, bus.game_reset, bus.auto_move};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %b (t=%0t)", tag, got, $time);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    // 1. reset with every button held high
    rst_n          = 1'b0;
    bus.btn_left   = 1'b1;
    bus.btn_right  = 1'b1;
    bus.btn_accept = 1'b1;
    bus.btn_reset  = 1'b1;
    bus.game_state = 3'b001;
    bus.win_flag   = 1'b0;
    step();
    step();
    check("rst_out", outs(), 8'b00000);
    check("rst_sec", {4'd0, bus.seconds}, 8'd0);

    // 2. timeout: IDLE->PLAY on edge 1, seconds 1,2,3 after edges 5,9,13
    rst_n          = 1'b1;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.btn_accept = 1'b0;
    bus.btn_reset  = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      check("t2_out", outs(), 8'b00000);
      check("t2_sec", {4'd0, bus.seconds}, 8'((i - 1) / 4));
    end
    step();
    check("t2_auto", outs(), 8'b00101);
    check("t2_sec0", {4'd0, bus.seconds}, 8'd0);
    step();
    check("t2_once", outs(), 8'b00000);

    // 3. accept lands on the cycle the timeout would fire
    for (int i = 0; i < 12; i++) step();
    check("t3_sec3", {4'd0, bus.seconds}, 8'd3);
    bus.btn_accept = 1'b1;
    step();
    bus.btn_accept = 1'b0;
    check("t3_out", outs(), 8'b00100);
    check("t3_sec", {4'd0, bus.seconds}, 8'd0);

    // 4. lockout after move_made, then simultaneous left+right
    bus.btn_left = 1'b1;
    step();
    bus.btn_left = 1'b0;
    check("t4_lock", outs(), 8'b00000);
    step();
    check("t4_idle", outs(), 8'b00000);
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b1;
    step();
    check("t4_both", outs(), 8'b00000);
    bus.btn_right = 1'b0;
    step();
    check("t4_left", outs(), 8'b10000);
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b1;
    step();
    bus.btn_right = 1'b0;
    check("t4_right", outs(), 8'b01000);

    // 5. win hold: 8 silent cycles (buttons ignored), one reset, no re-arm
    bus.win_flag   = 1'b1;
    bus.game_state = 3'b000;
    step();
    check("t5_enter", outs(), 8'b00000);
    for (int k = 1; k <= 7; k++) begin
      bus.btn_left   = (k == 2);
      bus.btn_accept = (k == 4);
      step();
      check("t5_hold", outs(), 8'b00000);
    end
    bus.btn_left   = 1'b0;
    bus.btn_accept = 1'b0;
    step();
    check("t5_reset", outs(), 8'b00010);
    for (int k = 0; k < 12; k++) begin
      step();
      check("t5_noarm", outs(), 8'b00000);
    end

    // 6. btn_reset aborts a win hold three cycles in
    bus.win_flag = 1'b0;
    step();
    check("t6_low", outs(), 8'b00000);
    bus.win_flag = 1'b1;
    step();
    check("t6_enter", outs(), 8'b00000);
    step();
    step();
    check("t6_hold", outs(), 8'b00000);
    bus.btn_reset = 1'b1;
    step();
    bus.btn_reset = 1'b0;
    check("t6_abort", outs(), 8'b00010);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t6_none", outs(), 8'b00000);
    end

    // 7. reset outranks accept/left; accept in IDLE is still forwarded
    bus.btn_reset  = 1'b1;
    bus.btn_accept = 1'b1;
    bus.btn_left   = 1'b1;
    step();
    bus.btn_reset  = 1'b0;
    bus.btn_left   = 1'b0;
    check("t7_prio", outs(), 8'b00010);
    step();
    check("t7_lock1", outs(), 8'b00000);
    step();
    check("t7_lock2", outs(), 8'b00000);
    step();
    bus.btn_accept = 1'b0;
    check("t7_idle_acc", outs(), 8'b00100);
    check("t7_sec", {4'd0, bus.seconds}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
